// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with occupancy count, programmable flags,
// overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for fall-through reads.
module sync_fifo_prog #(
  parameter int WIDTH    = 16,
  parameter int PTR      = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] write_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] read_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [PTR:0]     count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << PTR;
  localparam logic [PTR:0] CNT_FULL = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] CNT_AF   = (PTR+1)'(AF_LEVEL);
  localparam logic [PTR:0] CNT_AE   = (PTR+1)'(AE_LEVEL);
  localparam logic [PTR:0] CNT_ONE  = (PTR+1)'(1);
  localparam logic [PTR-1:0] PTR_ONE = PTR'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR-1:0]   wr_ptr;
  logic [PTR-1:0]   rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Flags come from the registered count only
  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_AF);
  assign almost_empty = (count <= CNT_AE);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      unique case (1'b1)
        (wr_acc && !rd_acc): count <= count + CNT_ONE;
        (rd_acc && !wr_acc): count <= count - CNT_ONE;
        default:             count <= count;
      endcase
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign read_data = empty ? '0 : mem[rd_ptr];
  assign rd_valid  = !empty;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) read_data <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: vector table, corner sequences and random traffic
// checked against a queue-based reference model.
module tb_sync_fifo_prog;

  localparam int W = 16;
  localparam int D = 8;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [W-1:0]  write_data;
  logic          rd_en;
  logic [W-1:0]  read_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  sync_fifo_prog dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .write_data  (write_data),
    .rd_en       (rd_en),
    .read_data   (read_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_rdata = '0;
  logic         m_rdv   = 1'b0;
  logic         m_ov    = 1'b0;
  logic         m_un    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input logic rd,
                            input logic [W-1:0] d);
    int n;
    logic [W-1:0] popped;
    n = q.size();
    if (r) begin
      q.delete();
      m_rdata = '0;
      m_rdv   = 1'b0;
      m_ov    = 1'b0;
      m_un    = 1'b0;
    end else begin
      m_ov = w && (n == D);
      m_un = rd && (n == 0);
      m_rdv = 1'b0;
      if (rd && n != 0) begin
        popped  = q.pop_front();
        m_rdata = popped;
        m_rdv   = 1'b1;
      end
      if (w && n != D) q.push_back(d);
    end
  endtask

  task automatic model_cmp();
    int n;
    n = q.size();
    chk("m_count", 32'(count), 32'(n));
    chk("m_full", 32'(full), 32'(n == D));
    chk("m_empty", 32'(empty), 32'(n == 0));
    chk("m_afull", 32'(almost_full), 32'(n >= 6));
    chk("m_aempty", 32'(almost_empty), 32'(n <= 2));
    chk("m_ovf", 32'(overflow), 32'(m_ov));
    chk("m_unf", 32'(underflow), 32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
    chk("m_rdv", 32'(rd_valid), 32'(n != 0));
    chk("m_rdata", 32'(read_data), (n != 0) ? 32'(q[0]) : 32'h0);
`else
    chk("m_rdv", 32'(rd_valid), 32'(m_rdv));
    chk("m_rdata", 32'(read_data), 32'(m_rdata));
`endif
  endtask

  task automatic step(input logic r, input logic w, input logic rd,
                      input logic [W-1:0] d);
    rst        = r;
    wr_en      = w;
    rd_en      = rd;
    write_data = d;
    @(posedge clk);
    model_edge(r, w, rd, d);
    #1;
    model_cmp();
  endtask

  typedef struct {
    logic         r;
    logic         w;
    logic         rd;
    logic [W-1:0] d;
    int           cnt;
    logic         ov;
    logic         un;
    logic         rdv;
    logic [W-1:0] rdata;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic w, input logic rd,
                     input logic [W-1:0] d, input int cnt, input logic ov,
                     input logic un, input logic rdv,
                     input logic [W-1:0] rdata);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd; v.d = d; v.cnt = cnt;
    v.ov = ov; v.un = un; v.rdv = rdv; v.rdata = rdata;
    tv.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    write_data = '0;

    // reset, 8 writes, overflow, 8 reads, underflow
    add(1, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      add(0, 1, 0, 16'(16'h1000 + i), i + 1, 0, 0, 1, 16'h1000);
`else
      add(0, 1, 0, 16'(16'h1000 + i), i + 1, 0, 0, 0, 16'h0);
`endif
    end
`ifdef SYNC_FIFO_FWFT_EN
    add(0, 1, 0, 16'h1008, 8, 1, 0, 1, 16'h1000);
    add(0, 0, 0, 16'h0, 8, 0, 0, 1, 16'h1000);
`else
    add(0, 1, 0, 16'h1008, 8, 1, 0, 0, 16'h0);
    add(0, 0, 0, 16'h0, 8, 0, 0, 0, 16'h0);
`endif
    for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      add(0, 0, 1, 16'h0, 7 - i, 0, 0, i < 7,
          (i < 7) ? 16'(16'h1001 + i) : 16'h0);
`else
      add(0, 0, 1, 16'h0, 7 - i, 0, 0, 1, 16'(16'h1000 + i));
`endif
    end
`ifdef SYNC_FIFO_FWFT_EN
    add(0, 0, 1, 16'h0, 0, 0, 1, 0, 16'h0);
    add(0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0);
`else
    add(0, 0, 1, 16'h0, 0, 0, 1, 0, 16'h1007);
    add(0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h1007);
`endif

    foreach (tv[k]) begin
      step(tv[k].r, tv[k].w, tv[k].rd, tv[k].d);
      chk("v_count", 32'(count), 32'(tv[k].cnt));
      chk("v_full", 32'(full), 32'(tv[k].cnt == 8));
      chk("v_empty", 32'(empty), 32'(tv[k].cnt == 0));
      chk("v_afull", 32'(almost_full), 32'(tv[k].cnt >= 6));
      chk("v_aempty", 32'(almost_empty), 32'(tv[k].cnt <= 2));
      chk("v_ovf", 32'(overflow), 32'(tv[k].ov));
      chk("v_unf", 32'(underflow), 32'(tv[k].un));
      chk("v_rdv", 32'(rd_valid), 32'(tv[k].rdv));
      chk("v_rdata", 32'(read_data), 32'(tv[k].rdata));
    end

    // wrap-around: write 6, read 4, write 6, read 8
    for (int i = 0; i < 6; i++) step(0, 1, 0, 16'(16'h2000 + i));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 16'(16'h2100 + i));
    chk("wrap_count", 32'(count), 32'd8);
    chk("wrap_full", 32'(full), 32'd1);
    step(0, 0, 1, 16'h0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("wrap_first", 32'(read_data), 32'h2004);
`endif
    for (int i = 0; i < 7; i++) step(0, 0, 1, 16'h0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("wrap_last", 32'(read_data), 32'h2105);
`endif
    chk("wrap_empty", 32'(empty), 32'd1);

    // simultaneous at count 3
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'(16'h3000 + i));
    step(0, 1, 1, 16'h3003);
    chk("sim3_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0);

    // simultaneous at full
    for (int i = 0; i < 8; i++) step(0, 1, 0, 16'(16'h4000 + i));
    step(0, 1, 1, 16'h4444);
    chk("simf_ovf", 32'(overflow), 32'd1);
    chk("simf_count", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 16'h0);

    // simultaneous at empty
    step(0, 1, 1, 16'h5555);
    chk("sime_unf", 32'(underflow), 32'd1);
    chk("sime_count", 32'(count), 32'd1);
    step(0, 0, 1, 16'h0);

    // reset mid-operation
    for (int i = 0; i < 5; i++) step(0, 1, 0, 16'(16'h6000 + i));
    step(1, 1, 1, 16'h6666);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_rdv", 32'(rd_valid), 32'd0);
    step(0, 1, 0, 16'hBEEF);
`ifdef SYNC_FIFO_FWFT_EN
    chk("beef", 32'(read_data), 32'hBEEF);
`endif
    step(0, 0, 1, 16'h0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("beef", 32'(read_data), 32'hBEEF);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 50,
           16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
